operand_issue_unit: RTL and testbench
=====================================

Name: operand_issue_unit

Overview:
- Multicycle issue/writeback stage sitting directly upstream of the 16-bit ALU.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it.
- Reads operands from an internal 8 x 16 register file and drives the ALU's opcode, data1 and data2 inputs from registers.
- Captures the ALU result and writes it back to the destination register.

Parameters:
- DATA_W, 16, datapath and register width; must equal the ALU data width.
- LDI_SIGNED, 1, when 1 the LDI 9-bit immediate is sign-extended to DATA_W; when 0 it is zero-extended.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instr_in  in  16  instruction word; sampled only when instr_valid and instr_ready are both high.
- instr_valid  in  1  upstream has an instruction on instr_in.
- instr_ready  out  1  unit can accept an instruction; high only in IDLE.
- alu_opcode  out  4  registered opcode presented to the ALU.
- alu_data1  out  DATA_W  registered operand A (rs).
- alu_data2  out  DATA_W  registered operand B (rt).
- alu_result  in  DATA_W  combinational ALU output; sampled in EXECUTE.
- wb_en  out  1  high for exactly the cycle a register write commits.
- wb_addr  out  3  destination register of the current writeback.
- wb_data  out  DATA_W  value being written.
- done  out  1  one-cycle pulse in WRITEBACK for every accepted instruction, including NOPs.
- dbg_addr  in  3  debug read address.
- dbg_data  out  DATA_W  combinational read of register dbg_addr; r0 always reads 0.

Behaviour:
- Instruction format:
  - opcode = [15:12], rd = [11:9], rs = [8:6], rt = [5:3]; bits [2:0] are ignored.
  - LDI uses imm9 = [8:0].
- Opcodes:
  - 0000 LDI.
  - 0010 add, 0011 sub, 0111 and, 1000 slt, 1001 sll; these are ALU ops.
  - Any other opcode is a NOP: no register write, done still pulses.
- Register file:
  - 8 x DATA_W. r0 reads as 0 and writes to it are discarded (wb_en still asserts, wb_addr = 0).
  - Every register resets to 0.
- FSM states are IDLE, DECODE, EXECUTE, WRITEBACK. Reset state is IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr_in into the IR and go to DECODE. Otherwise stay.
- DECODE:
  - Latch alu_opcode = opcode, alu_data1 = R[rs], alu_data2 = R[rt] (r0 reads 0).
  - ALU op -> EXECUTE.
  - LDI -> result register = extended imm9, then WRITEBACK (EXECUTE is skipped).
  - NOP -> WRITEBACK with the write suppressed.
- EXECUTE:
  - Operands are stable the whole cycle.
  - Capture alu_result into the result register, then go to WRITEBACK.
- WRITEBACK:
  - done = 1.
  - wb_en = 1 for ALU ops and LDI, 0 for NOP.
  - wb_addr = rd, wb_data = result. The write commits on the exiting edge.
  - Next state is IDLE.
- Latency, counted from the accept edge (cycle 0):
  - ALU op: done and wb_en high in cycle 3; register updated at the end of cycle 3.
  - LDI and NOP: done in cycle 2.
  - Next accept occurs in cycle 4 (ALU op) or cycle 3 (LDI/NOP) at the earliest.
- Output holding: alu_opcode, alu_data1 and alu_data2 hold their last values outside DECODE; the ALU output is only consumed in EXECUTE.
- Arithmetic: all results are truncated to DATA_W. No overflow or carry is reported.
- Read-after-write: a back-to-back dependent instruction reads the committed value, because the write lands before the next DECODE.
- Debug port: a dbg_data read of the address being written in the same cycle returns the old value.
- instr_valid outside IDLE is ignored. instr_in is not captured, and upstream must hold it.
- Reset mid-operation:
  - Immediately aborts the instruction with no writeback.
  - All registers, IR and result return to 0; alu_* return to 0.
  - wb_en, done and instr_ready return to 0; instr_ready rises to 1 once reset deasserts in IDLE.

Test Plan:
- Reset: assert reset mid-EXECUTE -> wb_en = 0 and done = 0 immediately; dbg_data = 0 for all 8 addresses; instr_ready = 1 after release.
- LDI sign handling: LDI r1 imm9 = 0x1FF with LDI_SIGNED = 1 -> done in cycle 2, dbg r1 = 0xFFFF. With LDI_SIGNED = 0 -> r1 = 0x01FF.
- add: r1 = 5, r2 = 7; add r3, r1, r2 -> alu_opcode = 0010, data1 = 5, data2 = 7 in EXECUTE; wb_en in cycle 3 with wb_addr = 3, wb_data = 12.
- sub wrap and slt: sub r4, r1, r2 -> r4 = 0xFFFE. slt r5, r1, r2 -> r5 = 1.
- r0 and NOP: LDI r0 0x055 -> wb_en = 1, dbg r0 still 0. Opcode 1111 -> done pulses, wb_en = 0, no register changes.
- Handshake and back-to-back: hold instr_valid high with two dependent adds (r6 = r1 + r2, then r7 = r6 + r6) -> second accept exactly 4 cycles after the first, r7 = 24; instr_ready is low during DECODE, EXECUTE and WRITEBACK.

Source files
------------

// File: rtl/operand_issue_unit.sv
// operand_issue_unit: multicycle issue/writeback stage in front of the 16-bit ALU.
// Accepts one instruction at a time, reads rs/rt from an 8-entry register
// file, presents registered operands to the ALU, and writes the result back to rd.
module operand_issue_unit #(
  parameter int DATA_W     = 16,
  parameter bit LDI_SIGNED = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]   alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0]   alu_data2_q, alu_data2_d;
  logic                wb_en_q, wb_en_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   regs_q [8];
  logic [DATA_W-1:0]   regs_d [8];

  // Instruction fields, always decoded from the latched IR.
  logic [3:0]        opcode;
  logic [2:0]        rd, rs, rt;
  logic [8:0]        imm9;
  logic [DATA_W-1:0] ldi_value;

  assign opcode    = ir_q[15:12];
  assign rd        = ir_q[11:9];
  assign rs        = ir_q[8:6];
  assign rt        = ir_q[5:3];
  assign imm9      = ir_q[8:0];
  assign ldi_value = {{(DATA_W-9){LDI_SIGNED & imm9[8]}}, imm9};

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL};
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

  // Next-state, datapath and register-file update for the four-phase sequence.
  always_comb begin
    // NOTE: every variable assigned here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    ir_d         = ir_q;
    result_d     = result_q;
    alu_opcode_d = alu_opcode_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    regs_d       = regs_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_opcode_d = opcode;
        alu_data1_d  = (rs == 3'd0) ? '0 : regs_q[rs];
        alu_data2_d  = (rt == 3'd0) ? '0 : regs_q[rt];
        if (is_alu_op(opcode)) begin
          state_d = S_EXECUTE;
        end else begin
          if (opcode == OP_LDI) result_d = ldi_value;
          state_d = S_WRITEBACK;
        end
      end
      S_EXECUTE: begin
        result_d = alu_result;
        state_d  = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // r0 is hard-wired to zero: the strobe still fires but nothing is stored.
        if (wb_en_q && (rd != 3'd0)) regs_d[rd] = result_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake and writeback strobes are registered from the state being entered.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_WRITEBACK);
    wb_en_d = (state_d == S_WRITEBACK) && writes_reg(opcode);
  end

  // State, pipeline registers and register file; reset aborts any instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      result_q     <= '0;
      alu_opcode_q <= '0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      wb_en_q      <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      // NOTE: the register file is architecturally visible and must read zero
      // after reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the values computed before this edge.
      state_q      <= state_d;
      ir_q         <= ir_d;
      result_q     <= result_d;
      alu_opcode_q <= alu_opcode_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      wb_en_q      <= wb_en_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      regs_q       <= regs_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_data1   = alu_data1_q;
  assign alu_data2   = alu_data2_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = rd;
  assign wb_data     = result_q;
  assign done        = done_q;

  // Debug read sees the pre-write value during the writeback cycle.
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_operand_issue_unit.sv
// Bench for operand_issue_unit: two instances (sign- and zero-extending LDI)
// share stimulus; a behavioural model of the register file predicts results.
module tb_operand_issue_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic [2:0]  dbg_addr;

  logic        instr_ready_s, instr_ready_u;
  logic [3:0]  alu_opcode_s, alu_opcode_u;
  logic [15:0] alu_data1_s, alu_data1_u, alu_data2_s, alu_data2_u;
  logic [15:0] alu_result_s, alu_result_u;
  logic        wb_en_s, wb_en_u, done_s, done_u;
  logic [2:0]  wb_addr_s, wb_addr_u;
  logic [15:0] wb_data_s, wb_data_u, dbg_data_s, dbg_data_u;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected architectural register contents for each instance.
  logic [15:0] ms [8];
  logic [15:0] mu [8];

  always #10 clock = ~clock;

  // Reference ALU: plain arithmetic on integers, truncated to 16 bits.
  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ia, ib, sa, sb;
    ia = longint'(a);
    ib = longint'(b);
    sa = (ia >= 32768) ? ia - 65536 : ia;
    sb = (ib >= 32768) ? ib - 65536 : ib;
    case (op)
      4'd2:    return 16'(ia + ib);
      4'd3:    return 16'(ia - ib);
      4'd7:    return a & b;
      4'd8:    return (sa < sb) ? 16'd1 : 16'd0;
      4'd9:    return 16'(ia * (longint'(1) << b[3:0]));
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] ext9(input logic [8:0] imm, input bit sgn);
    int v;
    v = int'(imm);
    if (sgn && v >= 256) v = v - 512;
    return 16'(v);
  endfunction

  assign alu_result_s = alu_ref(alu_opcode_s, alu_data1_s, alu_data2_s);
  assign alu_result_u = alu_ref(alu_opcode_u, alu_data1_u, alu_data2_u);

  operand_issue_unit #(.DATA_W(16), .LDI_SIGNED(1'b1)) dut_s (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready_s), .alu_opcode(alu_opcode_s), .alu_data1(alu_data1_s),
    .alu_data2(alu_data2_s), .alu_result(alu_result_s), .wb_en(wb_en_s),
    .wb_addr(wb_addr_s), .wb_data(wb_data_s), .done(done_s), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_s)
  );

  operand_issue_unit #(.DATA_W(16), .LDI_SIGNED(1'b0)) dut_u (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready_u), .alu_opcode(alu_opcode_u), .alu_data1(alu_data1_u),
    .alu_data2(alu_data2_u), .alu_result(alu_result_u), .wb_en(wb_en_u),
    .wb_addr(wb_addr_u), .wb_data(wb_data_u), .done(done_u), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_u)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sweep the debug port over all registers (8 ns, well inside a half period).
  task automatic check_regs(input string tag);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      check({tag, "_s"}, dbg_data_s, ms[a]);
      check({tag, "_u"}, dbg_data_u, mu[a]);
    end
  endtask

  // Issue one instruction from a negedge in IDLE and follow it to the next IDLE cycle.
  // With hold set, instr_valid stays high and next_ins is presented once the first is taken.
  task automatic issue(input logic [15:0] ins, input bit hold, input logic [15:0] next_ins,
                       output time t_acc);
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] exp_s, exp_u;
    int          kind, last;
    op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
    if (op == 4'd0) begin
      kind = 1; exp_s = ext9(ins[8:0], 1'b1); exp_u = ext9(ins[8:0], 1'b0);
    end else if (op inside {4'd2, 4'd3, 4'd7, 4'd8, 4'd9}) begin
      kind = 2; exp_s = alu_ref(op, ms[rs], ms[rt]); exp_u = alu_ref(op, mu[rs], mu[rt]);
    end else begin
      kind = 0; exp_s = 16'd0; exp_u = 16'd0;
    end
    last = (kind == 2) ? 3 : 2;

    check("ready_idle", instr_ready_s, 1);
    check("ready_idle_u", instr_ready_u, 1);
    instr_in    = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    t_acc = $time;

    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      if (k == 1) begin
        if (hold) instr_in = next_ins;
        else      instr_valid = 1'b0;
      end
      check("ready_busy", instr_ready_s, 0);
      check("done", done_s, 32'(k == last));
      check("done_u", done_u, 32'(k == last));
      check("wb_en", wb_en_s, 32'((k == last) && (kind != 0)));
      check("wb_en_u", wb_en_u, 32'((k == last) && (kind != 0)));
      if (k >= 2) begin
        check("alu_opcode", alu_opcode_s, op);
        check("alu_data1", alu_data1_s, ms[rs]);
        check("alu_data2", alu_data2_s, ms[rt]);
        check("alu_data1_u", alu_data1_u, mu[rs]);
        check("alu_data2_u", alu_data2_u, mu[rt]);
      end
      if (k == last && kind != 0) begin
        check("wb_addr", wb_addr_s, rd);
        check("wb_data", wb_data_s, exp_s);
        check("wb_data_u", wb_data_u, exp_u);
        dbg_addr = rd;
        #1;
        check("dbg_old", dbg_data_s, ms[rd]);
      end
    end

    if (kind != 0 && rd != 3'd0) begin
      ms[rd] = exp_s;
      mu[rd] = exp_u;
    end

    @(negedge clock);
    check("ready_after", instr_ready_s, 1);
    check("done_after", done_s, 0);
    check("wb_en_after", wb_en_s, 0);
    check_regs("regs");
  endtask

  // Accept an instruction, advance at_k cycles, then assert reset mid-flight.
  task automatic reset_during(input logic [15:0] ins, input int at_k, input bit done_before);
    instr_in    = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= at_k; k++) begin
      @(negedge clock);
      if (k == 1) instr_valid = 1'b0;
    end
    check("pre_rst_done", done_s, 32'(done_before));
    reset = 1'b1;
    #1;
    check("rst_done", done_s, 0);
    check("rst_wb_en", wb_en_s, 0);
    check("rst_ready", instr_ready_s, 0);
    check("rst_alu_opcode", alu_opcode_s, 0);
    check("rst_alu_data1", alu_data1_s, 0);
    check("rst_alu_data2", alu_data2_s, 0);
    check("rst_wb_data", wb_data_s, 0);
    check("rst_wb_addr", wb_addr_s, 0);
    for (int a = 0; a < 8; a++) begin
      ms[a] = 16'd0;
      mu[a] = 16'd0;
    end
    check_regs("rst_regs");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_ready", instr_ready_s, 1);
    check("rst_release_done", done_s, 0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  alu_ops [5];
    logic [3:0]  nop_ops [10];
    logic [15:0] w;
    int          sel;
    alu_ops = '{4'd2, 4'd3, 4'd7, 4'd8, 4'd9};
    nop_ops = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    w   = 16'($urandom);
    sel = int'($urandom_range(0, 7));
    if (sel < 3)       w[15:12] = 4'd0;
    else if (sel < 7)  w[15:12] = alu_ops[$urandom_range(0, 4)];
    else               w[15:12] = nop_ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time         t1, t2, t_dummy;
    logic [15:0] cur, nxt;
    bit          hold;

    for (int a = 0; a < 8; a++) begin
      ms[a] = 16'd0;
      mu[a] = 16'd0;
    end
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr_in    = 16'd0;
    dbg_addr    = 3'd0;
    #2 reset = 1'b1;
    #1;
    check("init_ready", instr_ready_s, 0);
    check("init_done", done_s, 0);
    check("init_wb_en", wb_en_s, 0);
    check("init_alu_opcode", alu_opcode_s, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("init_ready_release", instr_ready_s, 1);
    check_regs("init_regs");

    // LDI sign handling: signed instance gets 0xFFFF, unsigned gets 0x01FF.
    issue({4'h0, 3'd1, 9'h1FF}, 1'b0, 16'd0, t_dummy);
    // Operand setup, then add / sub wrap / slt.
    issue({4'h0, 3'd1, 9'd5}, 1'b0, 16'd0, t_dummy);
    issue({4'h0, 3'd2, 9'd7}, 1'b0, 16'd0, t_dummy);
    issue({4'h2, 3'd3, 3'd1, 3'd2, 3'd0}, 1'b0, 16'd0, t_dummy);
    check("add_r3", ms[3], 16'd12);
    issue({4'h3, 3'd4, 3'd1, 3'd2, 3'd0}, 1'b0, 16'd0, t_dummy);
    check("sub_r4", ms[4], 16'hFFFE);
    issue({4'h8, 3'd5, 3'd1, 3'd2, 3'd0}, 1'b0, 16'd0, t_dummy);
    check("slt_r5", ms[5], 16'd1);
    // r0 write is discarded; NOP pulses done without writing.
    issue({4'h0, 3'd0, 9'h055}, 1'b0, 16'd0, t_dummy);
    issue(16'hFABC, 1'b0, 16'd0, t_dummy);
    // Back-to-back dependent adds with instr_valid held high.
    issue({4'h2, 3'd6, 3'd1, 3'd2, 3'd0}, 1'b1, {4'h2, 3'd7, 3'd6, 3'd6, 3'd0}, t1);
    issue({4'h2, 3'd7, 3'd6, 3'd6, 3'd0}, 1'b0, 16'd0, t2);
    check("b2b_gap_ns", 32'(t2 - t1), 32'd80);
    check("b2b_r7", ms[7], 16'd24);

    // Reset in the middle of EXECUTE, and again during an LDI writeback.
    reset_during({4'h2, 3'd3, 3'd1, 3'd2, 3'd0}, 2, 1'b0);
    issue({4'h0, 3'd2, 9'h123}, 1'b0, 16'd0, t_dummy);
    reset_during({4'h0, 3'd1, 9'h0AA}, 2, 1'b1);

    // Randomized sequence, occasionally keeping instr_valid asserted between instructions.
    cur = rand_instr();
    for (int i = 0; i < 60; i++) begin
      hold = (i == 59) ? 1'b0 : 1'(($urandom_range(0, 1)));
      nxt  = rand_instr();
      issue(cur, hold, nxt, t_dummy);
      cur = nxt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
